alu_issue_unit: RTL and testbench

Sequential front end for the combinational `alu`: drives its `a`, `b`, `cin` and `opcode` inputs and consumes its `y` and `flags` outputs. Accepts operation requests over a valid/ready handshake and executes one per cycle through a single registered execute stage. Maintains the integer condition-code register (icc) that feeds carry-in for carry-using ops. Returns tagged results through a 2-entry response buffer with backpressure. Sits between decode/issue and writeback in the SPARC integer datapath.

---
 rtl/alu_pkg.sv | 43 ++++
 rtl/alu.sv | 64 ++++++
 rtl/alu_rsp_fifo.sv | 51 +++++
 rtl/alu_issue_unit.sv | 115 +++++++++++
 tb/tb_alu_issue_unit.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the SPARC integer ALU and its issue front end:
// opcode encodings, condition-code bit positions and response field widths.
package alu_pkg;

    localparam int OPC_W     = 4;
    localparam int FLAGS_W   = 4;
    localparam int RSP_DEPTH = 2;
    localparam int CNT_W     = 2;

    localparam logic [CNT_W-1:0] RSP_FULL = 2'd2;

    localparam logic [OPC_W-1:0] OP_ADD   = 4'h0;
    localparam logic [OPC_W-1:0] OP_ADDX  = 4'h1;
    localparam logic [OPC_W-1:0] OP_SUB   = 4'h2;
    localparam logic [OPC_W-1:0] OP_SUBX  = 4'h3;
    localparam logic [OPC_W-1:0] OP_AND   = 4'h4;
    localparam logic [OPC_W-1:0] OP_OR    = 4'h5;
    localparam logic [OPC_W-1:0] OP_XOR   = 4'h6;
    localparam logic [OPC_W-1:0] OP_ANDN  = 4'h7;
    localparam logic [OPC_W-1:0] OP_ORN   = 4'h8;
    localparam logic [OPC_W-1:0] OP_XNOR  = 4'h9;
    localparam logic [OPC_W-1:0] OP_SLL   = 4'hA;
    localparam logic [OPC_W-1:0] OP_SRL   = 4'hB;
    localparam logic [OPC_W-1:0] OP_SRA   = 4'hC;
    localparam logic [OPC_W-1:0] OP_PASSB = 4'hD;

    localparam int ICC_N = 3;
    localparam int ICC_Z = 2;
    localparam int ICC_V = 1;
    localparam int ICC_C = 0;

    function automatic logic [FLAGS_W-1:0] pack_flags(input logic n, input logic z,
                                                      input logic v, input logic c);
        logic [FLAGS_W-1:0] f;
        f        = '0;
        f[ICC_N] = n;
        f[ICC_Z] = z;
        f[ICC_V] = v;
        f[ICC_C] = c;
        return f;
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational SPARC integer ALU: add/sub with and without carry, logic ops
// and shifts, producing {N,Z,V,C}. C on subtract is the borrow, as in SPARC.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               cin,
    input  logic [OPC_W-1:0]   opcode,
    output logic [WIDTH-1:0]   y,
    output logic [FLAGS_W-1:0] flags
);

    localparam int SH_W = $clog2(WIDTH);

    logic [WIDTH:0]    sum;
    logic [SH_W-1:0]   sh;
    logic signed [WIDTH-1:0] a_s;
    logic              v;
    logic              c;

    assign sh  = b[SH_W-1:0];
    assign a_s = a;

    always_comb begin
        sum = '0;
        y   = '0;
        v   = 1'b0;
        c   = 1'b0;
        case (opcode)
            OP_ADD, OP_ADDX: begin
                sum = {1'b0, a} + {1'b0, b}
                    + (WIDTH+1)'((opcode == OP_ADDX) ? cin : 1'b0);
                y   = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                v   = (a[WIDTH-1] == b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB, OP_SUBX: begin
                // Top bit of the widened difference is the borrow out.
                sum = {1'b0, a} - {1'b0, b}
                    - (WIDTH+1)'((opcode == OP_SUBX) ? cin : 1'b0);
                y   = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                v   = (a[WIDTH-1] != b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:   y = a & b;
            OP_OR:    y = a | b;
            OP_XOR:   y = a ^ b;
            OP_ANDN:  y = a & ~b;
            OP_ORN:   y = a | ~b;
            OP_XNOR:  y = ~(a ^ b);
            OP_SLL:   y = a << sh;
            OP_SRL:   y = a >> sh;
            OP_SRA:   y = a_s >>> sh;
            OP_PASSB: y = b;
            default:  y = '0;
        endcase
    end

    assign flags = pack_flags(y[WIDTH-1], (y == '0), v, c);

endmodule

// File: rtl/alu_rsp_fifo.sv
// Two-entry synchronous response FIFO. Push and pop together are legal even
// when full; storage resets to zero so an empty head reads as zero.
module alu_rsp_fifo
    import alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     din,
    output logic [W-1:0]     dout,
    output logic [CNT_W-1:0] count
);

    logic [W-1:0] mem [RSP_DEPTH];
    logic         rd_ptr;
    logic         wr_ptr;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != RSP_FULL) || do_pop);
    assign dout    = mem[rd_ptr];

    // When full, wr_ptr == rd_ptr: a simultaneous push refills the slot being
    // popped while the read pointer moves on to the older survivor.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < RSP_DEPTH; i++) mem[i] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= '0;
        end else if (clr) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) rd_ptr <= ~rd_ptr;
            if (do_push && !do_pop)      count <= count + CNT_W'(1);
            else if (do_pop && !do_push) count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_issue_unit.sv
// Issue front end for the integer ALU: one registered execute stage, icc
// ownership with carry forwarding, and a 2-deep tagged response buffer.
module alu_issue_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [WIDTH-1:0]   req_a,
    input  logic [WIDTH-1:0]   req_b,
    input  logic [OPC_W-1:0]   req_opcode,
    input  logic               req_cin,
    input  logic               req_use_icc_c,
    input  logic               req_set_cc,
    input  logic [TAG_W-1:0]   req_tag,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [WIDTH-1:0]   rsp_y,
    output logic [FLAGS_W-1:0] rsp_flags,
    output logic [TAG_W-1:0]   rsp_tag,
    output logic [FLAGS_W-1:0] icc,
    input  logic               icc_wr_en,
    input  logic [FLAGS_W-1:0] icc_wr_data,
    input  logic               flush
);

    localparam int ENT_W = WIDTH + FLAGS_W + TAG_W;

    logic               vld_p0;
    logic [WIDTH-1:0]   a_p0;
    logic [WIDTH-1:0]   b_p0;
    logic [OPC_W-1:0]   op_p0;
    logic               cin_p0;
    logic               use_icc_p0;
    logic               set_cc_p0;
    logic [TAG_W-1:0]   tag_p0;

    logic               alu_cin;
    logic [WIDTH-1:0]   alu_y;
    logic [FLAGS_W-1:0] alu_flags;

    logic [CNT_W-1:0]   count;
    logic [ENT_W-1:0]   head;
    logic               buf_space;
    logic               fire;
    logic               accept;
    logic               push;
    logic               pop;

    assign rsp_valid = (count != '0);
    assign pop       = rsp_valid && rsp_ready;
    assign buf_space = (count != RSP_FULL) || pop;
    assign fire      = vld_p0 && buf_space;
    assign req_ready = !flush && (!vld_p0 || fire);
    assign accept    = req_valid && req_ready;
    assign push      = fire && !flush;

    // Execute stage (p0): request registered on accept, ALU evaluated in-cycle
    always_ff @(posedge clk) begin
        if (!rst_n)      vld_p0 <= 1'b0;
        else if (flush)  vld_p0 <= 1'b0;
        else if (accept) vld_p0 <= 1'b1;
        else if (fire)   vld_p0 <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            a_p0       <= req_a;
            b_p0       <= req_b;
            op_p0      <= req_opcode;
            cin_p0     <= req_cin;
            use_icc_p0 <= req_use_icc_c;
            set_cc_p0  <= req_set_cc;
            tag_p0     <= req_tag;
        end
    end

    // Carry comes from the live icc so a chained op sees the previous op's C.
    assign alu_cin = use_icc_p0 ? icc[ICC_C] : cin_p0;

    alu #(.WIDTH(WIDTH)) u_alu (
        .a      (a_p0),
        .b      (b_p0),
        .cin    (alu_cin),
        .opcode (op_p0),
        .y      (alu_y),
        .flags  (alu_flags)
    );

    // A set_cc op firing during flush still commits icc; only its result is lost.
    always_ff @(posedge clk) begin
        if (!rst_n)                  icc <= '0;
        else if (icc_wr_en)          icc <= icc_wr_data;
        else if (fire && set_cc_p0)  icc <= alu_flags;
    end

    // Response stage: buffered results, head drives rsp_*
    alu_rsp_fifo #(.W(ENT_W)) u_rsp_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .push  (push),
        .pop   (pop),
        .din   ({alu_y, alu_flags, tag_p0}),
        .dout  (head),
        .count (count)
    );

    assign {rsp_y, rsp_flags, rsp_tag} = head;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit with a scoreboard of expected responses.
module tb_alu_issue_unit;
    import alu_pkg::*;

    localparam int WIDTH = 32;
    localparam int TAG_W = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [WIDTH-1:0]  req_a;
    logic [WIDTH-1:0]  req_b;
    logic [3:0]        req_opcode;
    logic              req_cin;
    logic              req_use_icc_c;
    logic              req_set_cc;
    logic [TAG_W-1:0]  req_tag;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [WIDTH-1:0]  rsp_y;
    logic [3:0]        rsp_flags;
    logic [TAG_W-1:0]  rsp_tag;
    logic [3:0]        icc;
    logic              icc_wr_en;
    logic [3:0]        icc_wr_data;
    logic              flush;

    alu_issue_unit #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_opcode(req_opcode),
        .req_cin(req_cin), .req_use_icc_c(req_use_icc_c),
        .req_set_cc(req_set_cc), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_y(rsp_y), .rsp_flags(rsp_flags), .rsp_tag(rsp_tag),
        .icc(icc), .icc_wr_en(icc_wr_en), .icc_wr_data(icc_wr_data),
        .flush(flush)
    );

    always #5 clk = ~clk;

    typedef logic [WIDTH+4+TAG_W-1:0] ent_t;
    ent_t       q[$];
    int         errors = 0;
    int         checks = 0;
    int         rsp_count = 0;
    logic [3:0] model_icc = 4'b0000;

    // Reference ALU: overflow from wide signed arithmetic, borrow from compare.
    function automatic logic [35:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic cin);
        longint     sa, sb, sr;
        logic [32:0] u;
        logic [31:0] y;
        logic        v, c;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sr = 0; u = '0; c = 1'b0;
        case (op)
            OP_ADD:  begin u = {1'b0, a} + {1'b0, b}; sr = sa + sb; c = u[32]; end
            OP_ADDX: begin u = {1'b0, a} + {1'b0, b} + {32'd0, cin}; sr = sa + sb + longint'(cin); c = u[32]; end
            OP_SUB:  begin u = {1'b0, a} - {1'b0, b}; sr = sa - sb; c = (a < b); end
            OP_AND:  begin u = {1'b0, a & b}; sr = 0; end
            default: begin u = '0; sr = 0; end
        endcase
        y = u[31:0];
        v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        return {y, y[31], (y == 32'd0), v, c};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one request; on acceptance push its expected result and track icc.
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic use_icc, input logic set_cc,
                        input logic [3:0] tag, input int max_wait, output int waited);
        logic [35:0] r;
        req_valid = 1'b1; req_opcode = op; req_a = a; req_b = b;
        req_cin = cin; req_use_icc_c = use_icc; req_set_cc = set_cc; req_tag = tag;
        waited = 0;
        #1;
        while (!req_ready && waited <= max_wait) begin
            @(posedge clk);
            #2;
            waited++;
        end
        checks++;
        assert (req_ready) else begin
            errors++;
            $error("FAIL accept_tag%0d: observed req_ready=0 after %0d cycles expected acceptance", tag, waited);
        end
        if (req_ready) begin
            r = ref_alu(op, a, b, use_icc ? model_icc[ICC_C] : cin);
            q.push_back({r, tag});
            if (set_cc) model_icc = r[3:0];
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        assert (q.size() == 0) else begin
            errors++;
            $error("FAIL %s_drain: observed %0d pending expected 0", tag, q.size());
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            checks++;
            assert (q.size() != 0) else begin
                errors++;
                $error("FAIL rsp_unexpected: observed tag %0h with empty scoreboard expected no response", rsp_tag);
            end
            if (q.size() != 0) begin
                ent_t exp;
                exp = q.pop_front();
                check("rsp", {24'd0, rsp_y, rsp_flags, rsp_tag}, {24'd0, exp});
                rsp_count++;
            end
        end
    end

    initial begin
        int w;
        int seen;
        logic [3:0] icc_saved;

        rst_n = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; req_opcode = '0;
        req_cin = 1'b0; req_use_icc_c = 1'b0; req_set_cc = 1'b0; req_tag = '0;
        rsp_ready = 1'b0; icc_wr_en = 1'b0; icc_wr_data = '0; flush = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        #1;
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_icc", icc, 0);
        check("reset_req_ready", req_ready, 1);
        check("reset_rsp_y", rsp_y, 0);
        check("reset_rsp_flags_tag", {rsp_flags, rsp_tag}, 0);
        tick();

        // Basic ADD with 2-edge latency
        rsp_ready = 1'b1;
        send(OP_ADD, 32'd1, 32'd3, 1'b0, 1'b0, 1'b1, 4'd5, 4, w);
        check("lat_e0_rsp_valid", rsp_valid, 0);
        tick();
        check("lat_e1_rsp_valid", rsp_valid, 1);
        check("add_y", rsp_y, 32'd4);
        check("add_flags", rsp_flags, 4'b0000);
        check("add_tag", rsp_tag, 4'd5);
        check("add_icc", icc, 4'b0000);
        tick();

        // Carry chain: ADD sets C, ADDX back-to-back consumes it
        send(OP_ADD, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b1, 4'd1, 4, w);
        send(OP_ADDX, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 4'd2, 4, w);
        check("chain_addx_no_stall", w, 0);
        check("chain_add_flags", rsp_flags, 4'b0101);
        check("chain_icc", icc, 4'b0101);
        drain("chain");
        check("chain_icc_kept", icc, 4'b0101);

        // Overflow, borrow and logic-op flags
        send(OP_SUB, 32'h8000_0000, 32'd1, 1'b0, 1'b0, 1'b1, 4'd3, 4, w);
        send(OP_SUB, 32'd5, 32'd7, 1'b0, 1'b0, 1'b1, 4'd4, 4, w);
        send(OP_AND, 32'h0000_F0F0, 32'h0000_FF00, 1'b0, 1'b0, 1'b0, 4'd5, 4, w);
        send(OP_ADD, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b1, 4'd6, 4, w);
        drain("flags");
        check("flags_icc", icc, model_icc);

        // Backpressure: three ops held, fourth stalls until rsp_ready
        rsp_ready = 1'b0;
        seen = rsp_count;
        for (int i = 0; i < 3; i++)
            send(OP_ADD, 32'(i * 16), 32'd7, 1'b0, 1'b0, 1'b0, 4'(i), 4, w);
        req_valid = 1'b1; req_opcode = OP_ADD; req_a = 32'd48; req_b = 32'd7;
        req_use_icc_c = 1'b0; req_set_cc = 1'b0; req_tag = 4'd3;
        #1;
        check("full_req_ready", req_ready, 0);
        check("full_rsp_valid", rsp_valid, 1);
        @(posedge clk); #2;
        check("full_req_ready_held", req_ready, 0);
        rsp_ready = 1'b1;
        send(OP_ADD, 32'd48, 32'd7, 1'b0, 1'b0, 1'b0, 4'd3, 4, w);
        check("full_fourth_accept_wait", w, 0);
        drain("stream");
        check("stream_rsp_count", rsp_count - seen, 4);

        // Flush with two buffered and one executing
        rsp_ready = 1'b0;
        send(OP_ADD, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 4'd8, 4, w);
        send(OP_SUB, 32'd2, 32'd9, 1'b0, 1'b0, 1'b1, 4'd9, 4, w);
        icc_saved = model_icc;
        send(OP_ADD, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b1, 4'd10, 4, w);
        check("flush_pre_icc", icc, icc_saved);
        flush = 1'b1;
        req_valid = 1'b1; req_tag = 4'd15;
        #1;
        check("flush_req_ready", req_ready, 0);
        @(posedge clk); #1;
        flush = 1'b0; req_valid = 1'b0;
        q.delete();
        model_icc = icc_saved;
        check("flush_rsp_valid", rsp_valid, 0);
        check("flush_icc", icc, icc_saved);
        rsp_ready = 1'b1;
        send(OP_ADD, 32'd10, 32'd20, 1'b0, 1'b0, 1'b0, 4'd11, 4, w);
        check("flush_next_accept_wait", w, 0);
        drain("flush");

        // Explicit icc write beats a same-cycle set_cc fire
        send(OP_ADD, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 4'd12, 4, w);
        icc_wr_en = 1'b1; icc_wr_data = 4'b1010;
        tick();
        icc_wr_en = 1'b0;
        model_icc = 4'b1010;
        check("iccwr_icc", icc, 4'b1010);
        check("iccwr_rsp_flags", rsp_flags, 4'b0100);
        check("iccwr_rsp_tag", rsp_tag, 4'd12);
        drain("iccwr");

        // Reset with a full buffer
        rsp_ready = 1'b0;
        send(OP_ADD, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b1, 4'd13, 4, w);
        send(OP_ADD, 32'd5, 32'd6, 1'b0, 1'b0, 1'b0, 4'd14, 4, w);
        send(OP_ADD, 32'd7, 32'd8, 1'b0, 1'b0, 1'b1, 4'd15, 4, w);
        check("prerst_icc", icc, 4'b0101);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        q.delete();
        model_icc = 4'b0000;
        #1;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_y", rsp_y, 0);
        check("rst_rsp_flags_tag", {rsp_flags, rsp_tag}, 0);
        check("rst_icc", icc, 0);
        check("rst_req_ready", req_ready, 1);
        seen = rsp_count;
        rsp_ready = 1'b1;
        repeat (5) tick();
        check("rst_no_stale_valid", rsp_valid, 0);
        check("rst_no_stale_count", rsp_count - seen, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
